mc_controller: RTL
==================

# mc_controller

Multicycle main controller that sequences the shared single-memory MIPS datapath one instruction at a time. It decodes opcode/funct from the instruction register and drives every datapath select, enable and the 3-bit ALU control. It also handshakes with a single memory port that may insert wait states. It sits beside the datapath in the multicycle core and is the only source of its control signals.

## Interface
- `N`, 32: datapath width (informational; only opcode/funct slices consumed)
- `clk`  in  1  system clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `op`  in  6  instr[31:26] from instruction register
- `funct`  in  6  instr[5:0] from instruction register
- `zero`  in  1  ALU zero flag
- `memready`  in  1  memory completes current access this cycle
- `memreq`  out  1  memory access requested
- `memwrite`  out  1  request is a write
- `iord`  out  1  0 = address from PC, 1 = from ALU-out register
- `irwrite`  out  1  load instruction register
- `pcen`  out  1  PC register enable
- `regwrite`  out  1  register file write
- `regdst`  out  1  0 = rt, 1 = rd
- `memtoreg`  out  1  0 = ALU-out, 1 = data register
- `alusrca`  out  1  0 = PC, 1 = rs
- `alusrcb`  out  2  00 rt, 01 const 4, 10 signimm, 11 signimm<<2
- `pcsrc`  out  2  00 ALU result, 01 ALU-out register, 10 jump target
- `alucontrol`  out  3  010 add, 110 sub, 000 and, 001 or, 111 slt
- `illegal`  out  1  one-cycle pulse on undecodable opcode/funct

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP.
- FETCH: memreq=1, iord=0, alusrca=0, alusrcb=01, alucontrol=add, pcsrc=00. irwrite and pcen asserted only when memready=1; the state advances to DECODE only then, otherwise it stays.
- DECODE: alusrca=0, alusrcb=11, add (branch target precompute). Next state by op: lw/sw (100011/101011) go to MEMADR; R-type (000000) to EXECUTE; beq (000100) to BRANCH; addi (001000) to ADDIEX; j (000010) to JUMP; any other opcode pulses illegal and returns to FETCH.
- MEMADR: alusrca=1, alusrcb=10, add. Then MEMRD if lw, MEMWR if sw.
- MEMRD: memreq=1, iord=1. Waits for memready, then MEMWB.
- MEMWB: regwrite=1, regdst=0, memtoreg=1. Then FETCH.
- MEMWR: memreq=1, memwrite=1, iord=1. Waits for memready, then FETCH.
- EXECUTE: alusrca=1, alusrcb=00, alucontrol from funct (100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt). An unknown funct pulses illegal and goes to FETCH with no writeback; otherwise goes to ALUWB.
- ALUWB: regwrite=1, regdst=1, memtoreg=0. Then FETCH.
- BRANCH: alusrca=1, alusrcb=00, sub, pcsrc=01. pcen = zero. Then FETCH.
- ADDIEX: alusrca=1, alusrcb=10, add. Then ADDIWB, which does regwrite=1, regdst=0, memtoreg=0, then FETCH.
- JUMP: pcsrc=10, pcen=1. Then FETCH.
- All outputs not listed for a state are 0. Select outputs are 0 when they are don't-care.

## Timing
- Reset: the state register loads FETCH on the first rising edge with rst=1. While rst is held, all outputs are 0 except FETCH selects; memreq, pcen and irwrite are forced 0. Reset mid-instruction abandons the instruction, and no further regwrite or memwrite occurs.
- Outputs are Moore (decoded from state). Exceptions: pcen, irwrite and illegal are Mealy, combinational on memready, zero and op/funct in the current cycle.
- Latency with memready=1 on first request: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3 cycles. Each cycle memready=0 adds one cycle.
- Memory handshake: memreq stays high and the address selects stay stable until a cycle with memready=1. memready is ignored when memreq=0.
- A memready=1 coinciding with rst=1 is ignored.

## Configuration
- `MC_CONTROLLER_BNE_EN`
  - Defined: opcode 000101 (bne) is legal. DECODE goes to BRANCH, which behaves as for beq with pcen = ~zero; latency is 3.
  - Undefined: 000101 is illegal, as described in DECODE.

## Structure
- Package `mc_ctrl_pkg` holds:
  - state enum `mc_state_t`
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J)
  - funct constants
  - alucontrol constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT)
  - alusrcb and pcsrc encodings
- Sub-module `mc_aludec`: combinational funct-to-alucontrol decode, with a valid flag. It is instantiated once in `mc_controller`.

## Test plan
- Reset and fetch: assert rst for 2 cycles with memready=1, then release. Required: cycle 1 after release is FETCH with memreq=1, iord=0, irwrite=1, pcen=1, alusrcb=01, alucontrol=010.
- lw with wait states: op=100011, memready held 0 for 2 cycles in MEMRD. Required: 7-cycle instruction; regwrite=1 with memtoreg=1, regdst=0 only in the final cycle; iord=1 throughout MEMRD.
- R-type sub: op=000000, funct=100010. Required: EXECUTE alucontrol=110; ALUWB regwrite=1, regdst=1; 4 cycles total.
- beq taken/not taken: zero=1 gives pcen=1 and pcsrc=01 in BRANCH; zero=0 gives pcen=0. Both return to FETCH after 3 cycles.
- Illegal opcode: op=111111. Required: illegal=1 for exactly the DECODE cycle, then FETCH, with no regwrite or memwrite.
- Configuration: op=000101 with zero=0. Required: pcen=1 when `MC_CONTROLLER_BNE_EN` is defined, and illegal=1 when it is not.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle MIPS main controller.
// Build option: MC_CONTROLLER_BNE_EN makes opcode 000101 (bne) legal.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } mc_state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Opcodes the DECODE state can dispatch; anything else is reported as illegal.
  function automatic logic op_legal(input logic [5:0] op);
    logic ok;
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
`ifdef MC_CONTROLLER_BNE_EN
      OP_BNE:                                        ok = 1'b1;
`endif
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// R-type funct to ALU control decode; valid is low for unsupported functs.
module mc_aludec
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alucontrol,
  output logic       valid
);

  always_comb begin
    alucontrol = ALU_AND;
    valid      = 1'b1;
    case (funct)
      FUNCT_ADD: alucontrol = ALU_ADD;
      FUNCT_SUB: alucontrol = ALU_SUB;
      FUNCT_AND: alucontrol = ALU_AND;
      FUNCT_OR:  alucontrol = ALU_OR;
      FUNCT_SLT: alucontrol = ALU_SLT;
      default:   valid      = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS main controller: sequences the shared-memory datapath.
// Build option: MC_CONTROLLER_BNE_EN adds bne through the BRANCH state.
//
// state     | meaning
// FETCH     | read instruction at PC, PC <= PC+4 when memory is ready
// DECODE    | dispatch on opcode, precompute branch target into ALU-out
// MEMADR    | compute lw/sw effective address
// MEMRD     | read data memory, hold until memready
// MEMWB     | write loaded data into rt
// MEMWR     | write rt to memory, hold until memready
// EXECUTE   | R-type ALU operation selected by funct
// ALUWB     | write ALU-out into rd
// BRANCH    | compare rs/rt, take branch target from ALU-out
// ADDIEX    | rs + sign-extended immediate
// ADDIWB    | write ALU-out into rt
// JUMP      | load jump target into PC
module mc_controller
  import mc_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       memready,
  output logic       memreq,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       pcen,
  output logic       regwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal
);

  mc_state_t  state_q, state_d;
  mc_state_t  state_out;
  logic [2:0] funct_alu;
  logic       funct_valid;
  logic       branch_take;

  mc_aludec u_aludec (
    .funct      (funct),
    .alucontrol (funct_alu),
    .valid      (funct_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   if (memready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CONTROLLER_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   if (memready) state_d = S_MEMWB;
      S_MEMWB:   state_d = S_FETCH;
      S_MEMWR:   if (memready) state_d = S_FETCH;
      S_EXECUTE: state_d = funct_valid ? S_ALUWB : S_FETCH;
      S_ALUWB:   state_d = S_FETCH;
      S_BRANCH:  state_d = S_FETCH;
      S_ADDIEX:  state_d = S_ADDIWB;
      S_ADDIWB:  state_d = S_FETCH;
      S_JUMP:    state_d = S_FETCH;
      default:   state_d = S_FETCH;
    endcase
  end

`ifdef MC_CONTROLLER_BNE_EN
  assign branch_take = (op == OP_BNE) ? ~zero : zero;
`else
  assign branch_take = zero;
`endif

  // Under reset the outputs show FETCH selects regardless of the (possibly unknown) state.
  assign state_out = rst ? S_FETCH : state_q;

  always_comb begin
    memreq     = 1'b0;
    memwrite   = 1'b0;
    iord       = 1'b0;
    irwrite    = 1'b0;
    pcen       = 1'b0;
    regwrite   = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_RT;
    pcsrc      = PCSRC_ALU;
    alucontrol = ALU_AND;
    illegal    = 1'b0;
    case (state_out)
      S_FETCH: begin
        memreq     = 1'b1;
        alusrcb    = SRCB_FOUR;
        alucontrol = ALU_ADD;
        irwrite    = memready;
        pcen       = memready;
      end
      S_DECODE: begin
        alusrcb    = SRCB_IMMSH2;
        alucontrol = ALU_ADD;
        illegal    = ~op_legal(op);
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      S_MEMRD: begin
        memreq = 1'b1;
        iord   = 1'b1;
      end
      S_MEMWB: begin
        regwrite = 1'b1;
        memtoreg = 1'b1;
      end
      S_MEMWR: begin
        memreq   = 1'b1;
        memwrite = 1'b1;
        iord     = 1'b1;
      end
      S_EXECUTE: begin
        alusrca    = 1'b1;
        alucontrol = funct_alu;
        illegal    = ~funct_valid;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        regdst   = 1'b1;
      end
      S_BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        pcsrc      = PCSRC_ALUOUT;
        pcen       = branch_take;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = SRCB_IMM;
        alucontrol = ALU_ADD;
      end
      S_ADDIWB: regwrite = 1'b1;
      S_JUMP: begin
        pcsrc = PCSRC_JUMP;
        pcen  = 1'b1;
      end
      default: ;
    endcase
    if (rst) begin
      memreq  = 1'b0;
      irwrite = 1'b0;
      pcen    = 1'b0;
      illegal = 1'b0;
    end
  end

endmodule
